complex_fifo_byte_reader: RTL and testbench
===========================================

COMPLEX_FIFO_BYTE_READER -- requirements
Module: complex_fifo_byte_reader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  single clock, rising edge (same clock as the complex FIFO read side).
REQ-002 SHALL have rst_b_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL have en_i  input  1  drain enable; level-sensitive.
REQ-004 SHALL have fifo_empty_i  input  1  FIFO empty flag; registered in the FIFO and updated on the edge after a read.
REQ-005 SHALL have fifo_rd_en_o  output  1  FIFO read strobe; registered single-cycle pulse.
REQ-006 SHALL have fifo_data_i  input  32  FIFO word; I in [31:16], Q in [15:0]; valid on the edge after the fifo_rd_en_o cycle.
REQ-007 SHALL have byte_o  output  8  output byte.
REQ-008 SHALL have byte_valid_o  output  1  byte_o is valid.
REQ-009 SHALL have byte_ready_i  input  1  sink accepts; transfer occurs on a rising edge with byte_valid_o=1 and byte_ready_i=1.
REQ-010 SHALL have busy_o  output  1  any word is fetched, pending, or being sent.
REQ-011 SHALL have underrun_o  output  1  sticky flag: gap caused by an empty FIFO.
REQ-012 SHALL have sample_cnt_o  output  16  count of complete words sent.

Function
REQ-013 SHALL send each word as four bytes, in order: I[15:8], I[7:0], Q[15:8], Q[7:0].
REQ-014 SHALL hold a current-word shifter with a byte index 0..3 and a one-word prefetch register nxt with a valid bit.
REQ-015 SHALL issue fifo_rd_en_o only when all of these hold: en_i=1, fifo_empty_i=0, nxt not valid, no read outstanding, and fifo_rd_en_o low in the current cycle.
- Consequence: at least one idle cycle separates pulses, so a stale empty flag cannot cause an underflow read.
REQ-016 SHALL mark a read outstanding from the pulse until fifo_data_i is captured into nxt, on the edge after the pulse cycle.
REQ-017 SHALL have output FSM states IDLE (no current word, byte_valid_o=0) and SEND (byte_valid_o=1, byte_o selected by the index).
REQ-018 SHALL, in IDLE with nxt valid, load nxt into the current word, clear nxt valid, set index 0, and enter SEND on that edge.
REQ-019 SHALL hold byte_o and byte_valid_o stable in SEND while byte_ready_i=0.
REQ-020 SHALL, on a transfer at index 3:
- if nxt is valid, load nxt and stay in SEND with index 0, with no bubble;
- otherwise go to IDLE.
REQ-021 SHALL, in either case of REQ-020, increment sample_cnt_o modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-022 SHALL sustain 1 byte per clock (4-cycle word period) with byte_ready_i=1 and the FIFO non-empty, once the first byte is out.
REQ-023 SHALL have a first-byte latency of 3 edges from the first edge sampling en_i=1 and fifo_empty_i=0: pulse, capture, load.
REQ-024 SHALL, when en_i falls, issue no new reads, while the outstanding, nxt and current words are still sent in full.
REQ-025 SHALL drive busy_o = SEND | nxt valid | read outstanding.
REQ-026 SHALL set underrun_o when en_i=1, sample_cnt_o≠0, the FSM is IDLE and no word is available; it holds until en_i=0 and then clears on the next edge.
REQ-027 SHALL never assert byte_valid_o with undefined data, and SHALL never issue a read while fifo_empty_i=1.

Reset
REQ-028 SHALL, on rst_b_i=0 and asynchronously, force state=IDLE, index=0, nxt valid=0, outstanding=0, fifo_rd_en_o=0, byte_valid_o=0, byte_o=0x00, busy_o=0, underrun_o=0, sample_cnt_o=0x0000.
REQ-029 SHALL discard partial words on reset mid-word; after release the first transfer is byte 0 of a newly fetched word.

Structure
REQ-030 SHALL put the byte-index encoding (2 bits), the FSM state encoding and the word/byte widths (32/8) in the shared package with the complex FIFO width constants.
REQ-031 SHALL be a single module with no sub-module; the 4:1 byte mux and the shifter are inline.

Verification
REQ-032 SHALL cover reset then a single word: FIFO holds 0x1234ABCD, en_i=1, ready=1 -> bytes 0x12,0x34,0xAB,0xCD on consecutive cycles; first byte 3 edges after enable; sample_cnt_o=1; busy_o falls.
REQ-033 SHALL cover streaming: 8 words, ready=1 -> 32 consecutive byte_valid_o cycles, no bubbles; fifo_rd_en_o never high on two adjacent cycles; sample_cnt_o=8.
REQ-034 SHALL cover backpressure: ready toggles 1,0,0,1 -> every byte held while ready=0; order preserved; no read issued while nxt is valid.
REQ-035 SHALL cover underrun: 2 words then empty, en_i held -> underrun_o=1 after the 8th byte; en_i=0 -> cleared next edge.
REQ-036 SHALL cover counter wrap and mid-word reset: preload 0xFFFF count via 65535 words then 1 more -> count 0x0000; assert rst_b_i after byte 1 -> all outputs at reset values immediately, with the remaining bytes never sent.
REQ-037 SHALL cover disable mid-stream: en_i=0 during byte 2 with nxt valid -> current and next words complete (8 bytes total), then busy_o=0 and no further fifo_rd_en_o.

Source files
------------

// File: rtl/complex_fifo_byte_reader_pkg.sv
// Shared constants and types for the complex FIFO byte reader.
// A complex FIFO word carries I in the upper half and Q in the lower half.
package complex_fifo_byte_reader_pkg;

    // Complex FIFO geometry: one 16-bit I and one 16-bit Q per word
    localparam int CFIFO_IQ_W  = 16;
    localparam int CFIFO_WIDTH = 2 * CFIFO_IQ_W;

    // Reader datapath widths
    localparam int WORD_W = CFIFO_WIDTH;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 16;

    // Byte index within the current word (0 = I[15:8] ... 3 = Q[7:0])
    localparam int IDX_W = 2;
    typedef logic [IDX_W-1:0] byte_idx_t;
    localparam byte_idx_t IDX_FIRST = 2'd0;
    localparam byte_idx_t IDX_LAST  = 2'd3;

    // Output FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rd_state_e;

endpackage : complex_fifo_byte_reader_pkg

// File: rtl/complex_fifo_byte_reader.sv
// Drains complex words from a FIFO and serialises each one as four bytes
// (I high, I low, Q high, Q low) over a valid/ready byte interface.
// One prefetch register hides the FIFO read latency so a continuous
// stream runs at one byte per clock.
module complex_fifo_byte_reader
    import complex_fifo_byte_reader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_b_i,
    input  logic              en_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [WORD_W-1:0] fifo_data_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              busy_o,
    output logic              underrun_o,
    output logic [CNT_W-1:0]  sample_cnt_o
);

    // Read side: strobe, outstanding flag, prefetch word
    logic              rd_en_q,   rd_en_d;
    logic              outst_q,   outst_d;
    logic [WORD_W-1:0] nxt_q,     nxt_d;
    logic              nxt_vld_q, nxt_vld_d;

    // Output side: FSM, shifter, byte index, word counter, status
    rd_state_e         state_q,   state_d;
    byte_idx_t         idx_q,     idx_d;
    logic [WORD_W-1:0] cur_q,     cur_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              underrun_q, underrun_d;
    logic              busy_q,    busy_d;

    // Strobes between the two halves
    logic              capture_s;
    logic              take_nxt_s;

    // Read issue: never back-to-back, never with a word already pending
    always_comb begin
        rd_en_d   = en_i & ~fifo_empty_i & ~nxt_vld_q & ~outst_q & ~rd_en_q;
        capture_s = outst_q;
        if (rd_en_d) begin
            outst_d = 1'b1;
        end else if (capture_s) begin
            outst_d = 1'b0;
        end else begin
            outst_d = outst_q;
        end
    end

    // Prefetch register: filled by a returning read, emptied by the FSM
    always_comb begin
        nxt_d     = nxt_q;
        nxt_vld_d = nxt_vld_q;
        if (capture_s) begin
            nxt_d     = fifo_data_i;
            nxt_vld_d = 1'b1;
        end else if (take_nxt_s) begin
            nxt_vld_d = 1'b0;
        end else begin
            nxt_vld_d = nxt_vld_q;
        end
    end

    // Output FSM: load from prefetch, shift one byte per transfer
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        take_nxt_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (nxt_vld_q) begin
                    cur_d      = nxt_q;
                    idx_d      = IDX_FIRST;
                    take_nxt_s = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (byte_ready_i) begin
                    if (idx_q == IDX_LAST) begin
                        cnt_d = cnt_q + 16'd1;
                        idx_d = IDX_FIRST;
                        if (nxt_vld_q) begin
                            // Back-to-back word: no bubble between words
                            cur_d      = nxt_q;
                            take_nxt_s = 1'b1;
                            state_d    = ST_SEND;
                        end else begin
                            // Zero the shifter so byte_o reads 0 while idle
                            cur_d      = {WORD_W{1'b0}};
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        cur_d = {cur_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    // Backpressure: hold byte and index
                    cur_d = cur_q;
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_FIRST;
                cur_d   = {WORD_W{1'b0}};
            end
        endcase
    end

    // Status: sticky underrun while enabled, busy from next-state terms
    always_comb begin
        if (!en_i) begin
            underrun_d = 1'b0;
        end else if ((state_q == ST_IDLE) && (cnt_q != 16'd0) &&
                     !nxt_vld_q && !outst_q) begin
            underrun_d = 1'b1;
        end else begin
            underrun_d = underrun_q;
        end
        busy_d = (state_d == ST_SEND) | nxt_vld_d | outst_d;
    end

    // Read-side registers
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            rd_en_q   <= 1'b0;
            outst_q   <= 1'b0;
            nxt_q     <= {WORD_W{1'b0}};
            nxt_vld_q <= 1'b0;
        end else begin
            rd_en_q   <= rd_en_d;
            outst_q   <= outst_d;
            nxt_q     <= nxt_d;
            nxt_vld_q <= nxt_vld_d;
        end
    end

    // Output-side registers; reset drops any partially sent word
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_FIRST;
            cur_q      <= {WORD_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign byte_o       = cur_q[WORD_W-1 -: BYTE_W];
    assign byte_valid_o = (state_q == ST_SEND);
    assign busy_o       = busy_q;
    assign underrun_o   = underrun_q;
    assign sample_cnt_o = cnt_q;

endmodule : complex_fifo_byte_reader

// File: tb/tb_complex_fifo_byte_reader.sv
// Self-checking bench for complex_fifo_byte_reader: FIFO model plus a
// byte scoreboard fed at stimulus time and drained by the output monitor.
module tb_complex_fifo_byte_reader;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_data = 32'h0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        busy;
    logic        underrun;
    logic [15:0] sample_cnt;

    complex_fifo_byte_reader dut (
        .clk_i        (clk),
        .rst_b_i      (rst_b),
        .en_i         (en),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_data_i  (fifo_data),
        .byte_o       (byte_out),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready),
        .busy_o       (busy),
        .underrun_o   (underrun),
        .sample_cnt_o (sample_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem[$];
    logic [7:0]  exp_q[$];
    int          rd_cnt = 0;
    int          bytes_xfer = 0;
    bit          prev_rd = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b1;
    logic [7:0]  prev_byte = 8'h0;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        mem.push_back(w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},    32'(fifo_rd_en), 32'd0);
        check({tag, "_byte"},     32'(byte_out),   32'd0);
        check({tag, "_valid"},    32'(byte_valid), 32'd0);
        check({tag, "_busy"},     32'(busy),       32'd0);
        check({tag, "_underrun"}, 32'(underrun),   32'd0);
        check({tag, "_cnt"},      32'(sample_cnt), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        en = 1'b0;
        byte_ready = 1'b1;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        rst_b = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input bit need_empty, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (!busy && (!need_empty || exp_q.size() == 0)) done = 1'b1;
        end
        check({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (bytes_xfer == n) done = 1'b1;
        end
        check({tag, "_reach"}, 32'(done), 32'd1);
    endtask

    // FIFO model, scoreboard drain and interface-rule monitor
    always @(negedge clk) begin
        if (rst_b) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                check("rd_not_adjacent", 32'(prev_rd), 32'd0);
                check("rd_window", 32'(rd_cnt <= bytes_xfer / 4 + 2), 32'd1);
                check("rd_fifo_nonempty", 32'(mem.size() != 0), 32'd1);
                if (mem.size() != 0) fifo_data = mem.pop_front();
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(byte_valid), 32'd1);
                check("hold_byte", 32'(byte_out), 32'(prev_byte));
            end
            if (byte_valid && byte_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("byte_data", 32'(byte_out), 32'(exp_q.pop_front()));
                bytes_xfer++;
            end
            prev_rd    = fifo_rd_en;
            prev_valid = byte_valid;
            prev_ready = byte_ready;
            prev_byte  = byte_out;
        end else begin
            mem.delete();
            exp_q.delete();
            rd_cnt     = 0;
            bytes_xfer = 0;
            prev_rd    = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b1;
        end
        fifo_empty = (mem.size() == 0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h1234ABCD, 8'h12, 8'h34, 8'hAB, 8'hCD};
        tbl[1] = '{32'h80017FFE, 8'h80, 8'h01, 8'h7F, 8'hFE};
        tbl[2] = '{32'hA5A55A5A, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
        tbl[3] = '{32'h01020304, 8'h01, 8'h02, 8'h03, 8'h04};
        tbl[4] = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        tbl[5] = '{32'h7FFF8000, 8'h7F, 8'hFF, 8'h80, 8'h00};
        tbl[6] = '{32'h00FF00FF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        tbl[7] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        // Single word with first-byte latency
        do_reset("rst0");
        @(posedge clk); #1;
        push_word(32'h1234ABCD);
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_pulse", 32'(fifo_rd_en), 32'd1);
        check("lat_e1_valid", 32'(byte_valid), 32'd0);
        @(negedge clk);
        check("lat_e2_valid", 32'(byte_valid), 32'd0);
        check("lat_e2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_e3_valid", 32'(byte_valid), 32'd1);
        check("lat_e3_byte", 32'(byte_out), 32'h12);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("single_consec", 32'(byte_valid), 32'd1);
        end
        wait_idle(20, 1'b1, "single");
        check("single_cnt", 32'(sample_cnt), 32'd1);
        check("single_busy", 32'(busy), 32'd0);

        // Streaming from the vector table
        do_reset("rst1");
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            mem.push_back(tbl[i].word);
            exp_q.push_back(tbl[i].b0);
            exp_q.push_back(tbl[i].b1);
            exp_q.push_back(tbl[i].b2);
            exp_q.push_back(tbl[i].b3);
        end
        en = 1'b1;
        begin
            bit seen = 1'b0;
            int run = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (byte_valid) seen = 1'b1;
            end
            check("stream_start", 32'(seen), 32'd1);
            run = seen ? 1 : 0;
            for (int i = 0; i < 31; i++) begin
                @(negedge clk);
                if (byte_valid) run++;
            end
            check("stream_run", 32'(run), 32'd32);
            check("stream_no_underrun", 32'(underrun), 32'd0);
        end
        wait_idle(20, 1'b1, "stream");
        check("stream_cnt", 32'(sample_cnt), 32'd8);
        check("stream_reads", 32'(rd_cnt), 32'd8);

        // Backpressure with ready pattern 1,0,0,1
        do_reset("rst2");
        @(posedge clk); #1;
        push_word(32'hC0FFEE11);
        push_word(32'h2233AA55);
        push_word(32'h96C3E187);
        en = 1'b1;
        begin
            bit done = 1'b0;
            for (int c = 0; c < 300 && !done; c++) begin
                @(posedge clk); #1;
                byte_ready = ((c % 4) == 0) || ((c % 4) == 3);
                if (exp_q.size() == 0 && !busy) done = 1'b1;
            end
            check("bp_done", 32'(done), 32'd1);
        end
        byte_ready = 1'b1;
        check("bp_cnt", 32'(sample_cnt), 32'd3);
        check("bp_reads", 32'(rd_cnt), 32'd3);

        // Underrun after two words, cleared by disable
        do_reset("rst3");
        @(posedge clk); #1;
        push_word(32'h0F1E2D3C);
        push_word(32'h4B5A6978);
        en = 1'b1;
        wait_idle(40, 1'b1, "ur");
        @(negedge clk);
        check("ur_set", 32'(underrun), 32'd1);
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        check("ur_hold", 32'(underrun), 32'd1);
        @(negedge clk);
        check("ur_clear", 32'(underrun), 32'd0);

        // Counter wrap from a preloaded 0xFFFF
        do_reset("rst4");
        force dut.cnt_q = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        release dut.cnt_q;
        @(negedge clk);
        check("wrap_preload", 32'(sample_cnt), 32'hFFFF);
        @(posedge clk); #1;
        push_word(32'hCAFE0001);
        en = 1'b1;
        wait_idle(20, 1'b1, "wrap");
        check("wrap_cnt", 32'(sample_cnt), 32'h0000);

        // Reset in the middle of a word
        do_reset("rst5");
        @(posedge clk); #1;
        push_word(32'hDEADBEEF);
        en = 1'b1;
        wait_bytes(2, 20, "mid");
        @(posedge clk); #1;
        rst_b = 1'b0;
        #1;
        check_reset_outputs("mid_async");
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        push_word(32'h0BADF00D);
        wait_idle(20, 1'b1, "mid_after");
        check("mid_after_cnt", 32'(sample_cnt), 32'd1);
        check("mid_after_bytes", 32'(bytes_xfer), 32'd4);

        // Disable mid-stream with a word prefetched
        do_reset("rst6");
        @(posedge clk); #1;
        push_word(32'h11223344);
        push_word(32'h55667788);
        push_word(32'h99AABBCC);
        push_word(32'hDDEEFF00);
        en = 1'b1;
        wait_bytes(2, 20, "dis");
        @(posedge clk); #1;
        en = 1'b0;
        wait_idle(30, 1'b0, "dis");
        check("dis_bytes", 32'(bytes_xfer), 32'd8);
        check("dis_cnt", 32'(sample_cnt), 32'd2);
        check("dis_fifo_left", 32'(mem.size()), 32'd2);
        repeat (10) @(negedge clk);
        check("dis_no_more_reads", 32'(rd_cnt), 32'd2);
        check("dis_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_complex_fifo_byte_reader
